// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, serial shift, rotate, arithmetic shift, load, clear,
// with a saturating shift counter and a one-cycle completion pulse.
module univ_shift_reg #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
  localparam int                CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_ROTL  = 3'b011,
    M_ROTR  = 3'b100,
    M_LOAD  = 3'b101,
    M_ASR   = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;
  mode_e            op;

  assign op = mode_e'(mode);

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (op)
        M_HOLD:  q_d = q_q;
        M_SHL:   begin q_d = {q_q[WIDTH-2:0], sin_l};          is_shift = 1'b1; end
        M_SHR:   begin q_d = {sin_r, q_q[WIDTH-1:1]};          is_shift = 1'b1; end
        M_ROTL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};   is_shift = 1'b1; end
        M_ROTR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};         is_shift = 1'b1; end
        M_LOAD:  begin q_d = d;       cnt_d = '0; end
        M_ASR:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};   is_shift = 1'b1; end
        M_CLEAR: begin q_d = RST_VAL; cnt_d = '0; end
        default: q_d = q_q;
      endcase
      // Saturate at WIDTH; done fires only on the WIDTH-1 -> WIDTH transition.
      if (is_shift && cnt_q != CNT_MAX) begin
        cnt_d  = cnt_q + 1'b1;
        done_d = (cnt_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = q_q;
  assign sout_msb  = q_q[WIDTH-1];
  assign sout_lsb  = q_q[0];
  assign shift_cnt = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: an 8-bit default instance and a 5-bit instance
// with a non-zero reset value.
module tb_univ_shift_reg;

  logic       clk, rst;
  logic       en8, sl8, sr8;
  logic [2:0] md8;
  logic [7:0] d8, q8;
  logic       msb8, lsb8, dn8;
  logic [3:0] cnt8;

  logic       en5, sl5, sr5;
  logic [2:0] md5;
  logic [4:0] d5, q5;
  logic       msb5, lsb5, dn5;
  logic [2:0] cnt5;

  int n_chk = 0;
  int n_fail = 0;

  univ_shift_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en8), .mode(md8), .d(d8), .sin_l(sl8), .sin_r(sr8),
    .q(q8), .sout_msb(msb8), .sout_lsb(lsb8), .shift_cnt(cnt8), .done(dn8));

  univ_shift_reg #(.WIDTH(5), .RST_VAL(5'h1A)) u5 (
    .clk(clk), .rst(rst), .en(en5), .mode(md5), .d(d5), .sin_l(sl5), .sin_r(sr5),
    .q(q5), .sout_msb(msb5), .sout_lsb(lsb5), .shift_cnt(cnt5), .done(dn5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] eq, input logic [3:0] ec, input logic ed);
    chk({tag, ".q"}, 32'(q8), 32'(eq));
    chk({tag, ".cnt"}, 32'(cnt8), 32'(ec));
    chk({tag, ".done"}, 32'(dn8), 32'(ed));
  endtask

  task automatic chk5(input string tag, input logic [4:0] eq, input logic [2:0] ec, input logic ed);
    chk({tag, ".q"}, 32'(q5), 32'(eq));
    chk({tag, ".cnt"}, 32'(cnt5), 32'(ec));
    chk({tag, ".done"}, 32'(dn5), 32'(ed));
  endtask

  initial begin
    rst = 1'b0;
    en8 = 1'b0; md8 = 3'b000; d8 = 8'h00; sl8 = 1'b0; sr8 = 1'b0;
    en5 = 1'b0; md5 = 3'b000; d5 = 5'h00; sl5 = 1'b0; sr5 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk8("rst0", 8'h00, 4'd0, 1'b0);
    chk("rst0.msb", 32'(msb8), 32'd0);
    chk5("rst0_w5", 5'h1A, 3'd0, 1'b0);
    chk("rst0_w5.msb", 32'(msb5), 32'd1);
    chk("rst0_w5.lsb", 32'(lsb5), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Build q=A5 with shift_cnt=3: load B4, rotate left three times
    en8 = 1'b1; md8 = 3'b101; d8 = 8'hB4; tick();
    chk8("ld_b4", 8'hB4, 4'd0, 1'b0);
    md8 = 3'b011; tick(); chk8("rotl1", 8'h69, 4'd1, 1'b0);
    tick(); chk8("rotl2", 8'hD2, 4'd2, 1'b0);
    tick(); chk8("rotl3", 8'hA5, 4'd3, 1'b0);

    // Async reset between edges, then release with LOAD pending
    #2 rst = 1'b1;
    #1;
    chk8("async_rst", 8'h00, 4'd0, 1'b0);
    md8 = 3'b101; d8 = 8'hB4;
    #2 rst = 1'b0;
    tick(); chk8("post_rst_ld", 8'hB4, 4'd0, 1'b0);

    md8 = 3'b001; sl8 = 1'b1; tick();
    chk8("shl", 8'h69, 4'd1, 1'b0);
    chk("shl.msb", 32'(msb8), 32'd0);
    chk("shl.lsb", 32'(lsb8), 32'd1);
    md8 = 3'b010; sr8 = 1'b0; tick();
    chk8("shr", 8'h34, 4'd2, 1'b0);

    md8 = 3'b101; d8 = 8'h81; tick(); chk8("ld_81", 8'h81, 4'd0, 1'b0);
    md8 = 3'b011; tick(); chk8("rotl_81", 8'h03, 4'd1, 1'b0);
    md8 = 3'b100; tick(); chk8("rotr1", 8'h81, 4'd2, 1'b0);
    tick(); chk8("rotr2", 8'hC0, 4'd3, 1'b0);
    md8 = 3'b101; d8 = 8'h80; tick(); chk8("ld_80", 8'h80, 4'd0, 1'b0);
    md8 = 3'b110; tick(); chk8("asr1", 8'hC0, 4'd1, 1'b0);
    tick(); chk8("asr2", 8'hE0, 4'd2, 1'b0);
    tick(); chk8("asr3", 8'hF0, 4'd3, 1'b0);
    md8 = 3'b000; tick(); chk8("hold_en", 8'hF0, 4'd3, 1'b0);

    // Every mode with en=0 must change nothing
    en8 = 1'b0; d8 = 8'h5A; sl8 = 1'b1; sr8 = 1'b1;
    for (int m = 0; m < 8; m++) begin
      md8 = 3'(m);
      tick();
      chk8($sformatf("en0_m%0d", m), 8'hF0, 4'd3, 1'b0);
    end

    // Completion: 8 SHLs with a 2-cycle enable gap after the 4th
    en8 = 1'b1; md8 = 3'b101; d8 = 8'h01; tick(); chk8("ld_01", 8'h01, 4'd0, 1'b0);
    md8 = 3'b001; sl8 = 1'b0;
    tick(); chk8("c1", 8'h02, 4'd1, 1'b0);
    tick(); chk8("c2", 8'h04, 4'd2, 1'b0);
    tick(); chk8("c3", 8'h08, 4'd3, 1'b0);
    tick(); chk8("c4", 8'h10, 4'd4, 1'b0);
    en8 = 1'b0;
    tick(); chk8("gap1", 8'h10, 4'd4, 1'b0);
    tick(); chk8("gap2", 8'h10, 4'd4, 1'b0);
    en8 = 1'b1;
    tick(); chk8("c5", 8'h20, 4'd5, 1'b0);
    tick(); chk8("c6", 8'h40, 4'd6, 1'b0);
    tick(); chk8("c7", 8'h80, 4'd7, 1'b0);
    tick(); chk8("c8", 8'h00, 4'd8, 1'b1);
    sl8 = 1'b1;
    tick(); chk8("c9_sat", 8'h01, 4'd8, 1'b0);
    md8 = 3'b011; tick(); chk8("c10_sat", 8'h02, 4'd8, 1'b0);
    md8 = 3'b111; tick(); chk8("clr8", 8'h00, 4'd0, 1'b0);
    en8 = 1'b0;

    // 5-bit instance with RST_VAL=1A
    en5 = 1'b1; md5 = 3'b101; d5 = 5'h07; tick(); chk5("w5_ld", 5'h07, 3'd0, 1'b0);
    md5 = 3'b011; tick(); chk5("w5_rotl_pre", 5'h0E, 3'd1, 1'b0);
    md5 = 3'b111; tick(); chk5("w5_clr", 5'h1A, 3'd0, 1'b0);
    md5 = 3'b011;
    tick(); chk5("w5_r1", 5'h15, 3'd1, 1'b0);
    tick(); chk5("w5_r2", 5'h0B, 3'd2, 1'b0);
    tick(); chk5("w5_r3", 5'h16, 3'd3, 1'b0);
    tick(); chk5("w5_r4", 5'h0D, 3'd4, 1'b0);
    tick(); chk5("w5_r5", 5'h1A, 3'd5, 1'b1);
    tick(); chk5("w5_r6", 5'h15, 3'd5, 1'b0);
    en5 = 1'b0;
    tick(); chk5("w5_hold", 5'h15, 3'd5, 1'b0);
    chk8("w8_idle", 8'h00, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
